// File: rtl/video_pkg.sv
// Shared type definitions for the video timing blocks; holds the delay_measure FSM states.
package video_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } dm_state_e;

endpackage

// File: rtl/delay_measure.sv
// delay_measure: counts cycles from start to echo and yields a delay-line latency setting (N-1).
// Optional build macro DELAY_MEASURE_FILTER_EN: accept a result only when it repeats the previous raw one.
module delay_measure #(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            echo,
  output logic [SIZE-1:0] latency,
  output logic            valid,
  output logic            timeout,
  output logic            busy,
  output logic            locked
);
  import video_pkg::*;

  localparam logic [SIZE-1:0] CNT_MAX = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};

  dm_state_e       state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] latency_q, latency_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic            locked_q, locked_d;
  logic            raw_hit_s;
  logic            accept_s;
`ifdef DELAY_MEASURE_FILTER_EN
  logic [SIZE-1:0] prev_q, prev_d;
  logic            prev_ok_q, prev_ok_d;
`endif

  // FSM next state, counter and timeout detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    raw_hit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          cnt_d   = {SIZE{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        // echo wins over the saturation point so raw = 2^SIZE-1 stays measurable
        if (echo) begin
          state_d   = IDLE;
          raw_hit_s = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {SIZE{1'b0}};
      end
    endcase
    busy_d = (state_d == ARMED);
  end

  // Result acceptance: optionally require two identical raw results in a row
  always_comb begin
`ifdef DELAY_MEASURE_FILTER_EN
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    accept_s  = 1'b0;
    if (raw_hit_s) begin
      accept_s  = prev_ok_q && (prev_q == cnt_q);
      prev_d    = cnt_q;
      prev_ok_d = 1'b1;
    end else if (timeout_d) begin
      prev_ok_d = 1'b0;
    end else begin
      prev_ok_d = prev_ok_q;
    end
`else
    accept_s = raw_hit_s;
`endif
    latency_d = latency_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    if (accept_s) begin
      latency_d = cnt_q;
      valid_d   = 1'b1;
      locked_d  = 1'b1;
    end else begin
      latency_d = latency_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= {SIZE{1'b0}};
      latency_q <= {SIZE{1'b0}};
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
`ifdef DELAY_MEASURE_FILTER_EN
      prev_q    <= {SIZE{1'b0}};
      prev_ok_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latency_q <= latency_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
`ifdef DELAY_MEASURE_FILTER_EN
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
`endif
    end
  end

  assign latency = latency_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_delay_measure.sv
// Self-checking bench for delay_measure (SIZE=5): directed table, hand sequences and random trials.
// Honours DELAY_MEASURE_FILTER_EN so the reference model follows the same build option.
module tb_delay_measure;

`ifdef DELAY_MEASURE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, echo;
  logic [4:0] latency;
  logic       valid, timeout, busy, locked;

  int tests  = 0;
  int failed = 0;

  // reference model state: what the block should remember between measurements
  logic [4:0] lat_m;
  logic       locked_m;
  logic [4:0] prev_m;
  logic       prev_ok_m;

  typedef struct {
    int         n;
    int         stray;
    bit         meas;
    logic [4:0] raw;
  } vec_t;

  delay_measure #(.SIZE(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .echo(echo),
    .latency(latency), .valid(valid), .timeout(timeout), .busy(busy), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int cyc, input logic [8:0] exp_v);
    logic [8:0] act;
    act = {busy, valid, timeout, locked, latency};
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s cycle %0d: got busy/valid/timeout/locked/lat=%b want %b", name, cyc, act, exp_v);
    end
  endtask

  // One measurement: start at cycle 0, echo at cycle n, optional ignored start at cycle stray.
  task automatic run_trial(input string name, input int n, input int stray,
                           input bit meas, input logic [4:0] raw);
    bit         acc;
    bit         post;
    int         endc;
    logic [4:0] lat_e;
    logic       lock_e;
    acc  = meas && (!FILT || (prev_ok_m && prev_m == raw));
    endc = meas ? n : 32;
    for (int c = 0; c <= 40; c++) begin
      if (c >= 1) begin
        post   = (c > endc);
        lat_e  = (acc && post) ? raw : lat_m;
        lock_e = locked_m || (acc && post);
        chk(name, c, {c <= endc, acc && (c == n + 1), !meas && (c == 33), lock_e, lat_e});
      end
      start = (c == 0) || (stray > 0 && c == stray);
      echo  = (c == n);
      tick();
    end
    start = 1'b0;
    echo  = 1'b0;
    if (meas) begin
      prev_m    = raw;
      prev_ok_m = 1'b1;
      if (acc) begin
        lat_m    = raw;
        locked_m = 1'b1;
      end
    end else begin
      prev_ok_m = 1'b0;
    end
  endtask

  vec_t tbl[7];

  initial begin
    int         n, stray, endc, last_n;
    bit         meas;
    logic [4:0] raw;

    tbl[0] = '{n: 7,  stray: 0, meas: 1'b1, raw: 5'd6};
    tbl[1] = '{n: 1,  stray: 0, meas: 1'b1, raw: 5'd0};
    tbl[2] = '{n: 0,  stray: 0, meas: 1'b0, raw: 5'd0};
    tbl[3] = '{n: 5,  stray: 3, meas: 1'b1, raw: 5'd4};
    tbl[4] = '{n: 32, stray: 0, meas: 1'b1, raw: 5'd31};
    tbl[5] = '{n: 33, stray: 0, meas: 1'b0, raw: 5'd0};
    tbl[6] = '{n: 7,  stray: 2, meas: 1'b1, raw: 5'd6};

    lat_m = 5'd0; locked_m = 1'b0; prev_m = 5'd0; prev_ok_m = 1'b0;
    rst_n = 1'b0; start = 1'b0; echo = 1'b0;
    tick();
    tick();
    chk("reset_state", 0, 9'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_trial($sformatf("table%0d", i), tbl[i].n, tbl[i].stray, tbl[i].meas, tbl[i].raw);
    end

`ifdef DELAY_MEASURE_FILTER_EN
    // N=9, 10, 10: only the repeated result is accepted
    run_trial("filt_n9", 9, 0, 1'b1, 5'd8);
    run_trial("filt_n10a", 10, 0, 1'b1, 5'd9);
    run_trial("filt_n10b", 10, 0, 1'b1, 5'd9);
    tests++;
    if (latency !== 5'd9 || locked !== 1'b1) begin
      failed++;
      $display("FAIL filt_latency: got lat=%0d locked=%b want lat=9 locked=1", latency, locked);
    end
    // a timeout between two equal results breaks the pair
    run_trial("filt_n12a", 12, 0, 1'b1, 5'd11);
    run_trial("filt_to", 40, 0, 1'b0, 5'd0);
    run_trial("filt_n12b", 12, 0, 1'b1, 5'd11);
    tests++;
    if (latency !== 5'd9) begin
      failed++;
      $display("FAIL filt_after_timeout: got lat=%0d want 9", latency);
    end
`else
    // back-to-back: new start in the valid cycle of the previous result
    start = 1'b1; tick();
    start = 1'b0; tick();
    tick();
    echo = 1'b1; tick();
    echo = 1'b0;
    chk("b2b_first", 4, {1'b0, 1'b1, 1'b0, 1'b1, 5'd2});
    start = 1'b1; tick();
    start = 1'b0;
    chk("b2b_busy", 5, {1'b1, 1'b0, 1'b0, 1'b1, 5'd2});
    tick();
    echo = 1'b1; tick();
    echo = 1'b0;
    chk("b2b_second", 7, {1'b0, 1'b1, 1'b0, 1'b1, 5'd1});
    tick();
    lat_m = 5'd1; locked_m = 1'b1;
`endif

    // reset in the middle of a measurement, then a stale echo
    start = 1'b1; tick();
    start = 1'b0; tick();
    tick();
    tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("rst_mid", 5, 9'd0);
    tick();
    echo = 1'b1;
    chk("rst_idle", 6, 9'd0);
    tick();
    echo = 1'b0;
    chk("rst_echo_ignored", 7, 9'd0);
    tick();
    lat_m = 5'd0; locked_m = 1'b0; prev_ok_m = 1'b0;

    last_n = 7;
    for (int t = 0; t < 24; t++) begin
      n     = ($urandom_range(0, 2) == 0) ? last_n : int'($urandom_range(0, 40));
      meas  = (n >= 1 && n <= 32);
      raw   = meas ? 5'(n - 1) : 5'd0;
      endc  = meas ? n : 32;
      stray = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, endc)) : 0;
      last_n = n;
      run_trial($sformatf("rand%0d_n%0d", t, n), n, stray, meas, raw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
